// File: rtl/cmd_dispatch_if.sv
// Host command bus between uart_rx/uart_tx, the dump engine, the config registers
// and cmd_dispatch. The host-facing side is "master"; cmd_dispatch takes "slave".
interface cmd_dispatch_if;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       clr_rx_rdy;
    logic       dump_done;
    logic       tx_done;
    logic       start_dump;
    logic [1:0] dump_ch;
    logic [7:0] dump_addr;
    logic       cfg_wr;
    logic [7:0] cfg_addr;
    logic [7:0] cfg_data;
    logic [7:0] tx_data;
    logic       trmt;
    logic       busy;

    modport master (
        output rx_data, rx_rdy, dump_done, tx_done,
        input  clr_rx_rdy, start_dump, dump_ch, dump_addr, cfg_wr,
               cfg_addr, cfg_data, tx_data, trmt, busy
    );

    modport slave (
        input  rx_data, rx_rdy, dump_done, tx_done,
        output clr_rx_rdy, start_dump, dump_ch, dump_addr, cfg_wr,
               cfg_addr, cfg_data, tx_data, trmt, busy
    );
endinterface

// File: rtl/cmd_dispatch.sv
// Assembles 3-byte host commands (opcode/channel, data, address), then launches a
// channel dump or performs a config write answered with a 1-byte ACK/NAK.
module cmd_dispatch #(
    parameter int         TIMEOUT = 50000,
    parameter logic [7:0] ACK     = 8'hA5,
    parameter logic [7:0] NAK     = 8'hEE
) (
    input logic          clk,
    input logic          rst_n,
    cmd_dispatch_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [3:0] OP_DUMP = 4'h1;
    localparam logic [3:0] OP_CFG  = 4'h2;

    typedef enum logic [2:0] {
        GET0, GET1, GET2, DECODE, DUMP_WAIT, SEND, TX_WAIT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       opcode;
    logic [1:0]       channel;
    logic [7:0]       data_byte;

    logic       start_dump;
    logic       cfg_wr;
    logic       trmt;
    logic       busy;
    logic [1:0] dump_ch;
    logic [7:0] dump_addr;
    logic [7:0] cfg_addr;
    logic [7:0] cfg_data;
    logic [7:0] tx_data;

    // Every presented byte is consumed at once: accepted while assembling, dropped while busy.
    assign bus.clr_rx_rdy = bus.rx_rdy;
    assign bus.start_dump = start_dump;
    assign bus.cfg_wr     = cfg_wr;
    assign bus.trmt       = trmt;
    assign bus.busy       = busy;
    assign bus.dump_ch    = dump_ch;
    assign bus.dump_addr  = dump_addr;
    assign bus.cfg_addr   = cfg_addr;
    assign bus.cfg_data   = cfg_data;
    assign bus.tx_data    = tx_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= GET0;
            cnt        <= '0;
            start_dump <= 1'b0;
            cfg_wr     <= 1'b0;
            trmt       <= 1'b0;
            busy       <= 1'b0;
            dump_ch    <= '0;
            dump_addr  <= '0;
            cfg_addr   <= '0;
            cfg_data   <= '0;
            tx_data    <= '0;
        end else begin
            start_dump <= 1'b0;
            cfg_wr     <= 1'b0;
            trmt       <= 1'b0;
            case (state)
                GET0: begin
                    cnt <= '0;
                    if (bus.rx_rdy) begin
                        opcode  <= bus.rx_data[7:4];
                        channel <= bus.rx_data[1:0];
                        state   <= GET1;
                        busy    <= 1'b1;
                    end
                end
                GET1: begin
                    if (bus.rx_rdy) begin
                        data_byte <= bus.rx_data;
                        cnt       <= '0;
                        state     <= GET2;
                    end else if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= GET0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GET2: begin
                    if (bus.rx_rdy) begin
                        cnt   <= '0;
                        state <= DECODE;
                        // Strobes are registered here so they are high exactly during DECODE.
                        case (opcode)
                            OP_DUMP: begin
                                start_dump <= 1'b1;
                                dump_ch    <= channel;
                                dump_addr  <= bus.rx_data;
                            end
                            OP_CFG: begin
                                cfg_wr   <= 1'b1;
                                cfg_addr <= bus.rx_data;
                                cfg_data <= data_byte;
                                tx_data  <= ACK;
                            end
                            default: tx_data <= NAK;
                        endcase
                    end else if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= GET0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DECODE: begin
                    if (opcode == OP_DUMP) begin
                        state <= DUMP_WAIT;
                    end else begin
                        trmt  <= 1'b1;
                        state <= SEND;
                    end
                end
                SEND: state <= TX_WAIT;
                TX_WAIT: begin
                    if (bus.tx_done) begin
                        state <= GET0;
                        busy  <= 1'b0;
                    end
                end
                DUMP_WAIT: begin
                    if (bus.dump_done) begin
                        state <= GET0;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= GET0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cmd_dispatch.sv
// Bench for cmd_dispatch: vector table of complete commands, hand-written timeout /
// busy / reset sequences, and randomized commands against a transaction-level model.
module tb_cmd_dispatch;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cmd_dispatch_if bus ();

    cmd_dispatch #(.TIMEOUT(TO), .ACK(8'hA5), .NAK(8'hEE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] b0, b1, b2;
        logic       sd;
        logic [1:0] ch;
        logic [7:0] da;
        logic       cw;
        logic [7:0] ca, cd, tx;
    } vec_t;

    typedef struct {
        int         kind;   // 0 dump, 1 cfg write, 2 transmitted byte
        logic [7:0] a;
        logic [7:0] b;
    } ev_t;

    ev_t mon_q[$];
    ev_t exp_q[$];

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.start_dump === 1'b1) mon_q.push_back('{0, {6'd0, bus.dump_ch}, bus.dump_addr});
            if (bus.cfg_wr === 1'b1)     mon_q.push_back('{1, bus.cfg_addr, bus.cfg_data});
            if (bus.trmt === 1'b1)       mon_q.push_back('{2, bus.tx_data, 8'h00});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data = b;
        bus.rx_rdy  = 1'b1;
        #1;
        chk("clr_rx_rdy", bus.clr_rx_rdy, 1'b1);
        @(posedge clk);
        #1;
        bus.rx_rdy = 1'b0;
    endtask

    task automatic idle_cycles(input int n, input bit stray);
        for (int i = 0; i < n; i++) begin
            if (stray) begin
                bus.dump_done = ($urandom_range(0, 3) == 0);
                bus.tx_done   = ($urandom_range(0, 3) == 0);
            end
            step();
            bus.dump_done = 1'b0;
            bus.tx_done   = 1'b0;
        end
    endtask

    task automatic pulse_dump_done();
        bus.dump_done = 1'b1;
        step();
        bus.dump_done = 1'b0;
    endtask

    task automatic pulse_tx_done();
        bus.tx_done = 1'b1;
        step();
        bus.tx_done = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " start_dump"}, bus.start_dump, 1'b0);
        chk({tag, " cfg_wr"},     bus.cfg_wr, 1'b0);
        chk({tag, " trmt"},       bus.trmt, 1'b0);
        chk({tag, " busy"},       bus.busy, 1'b0);
        chk({tag, " dump_ch"},    bus.dump_ch, 2'd0);
        chk({tag, " dump_addr"},  bus.dump_addr, 8'h00);
        chk({tag, " cfg_addr"},   bus.cfg_addr, 8'h00);
        chk({tag, " cfg_data"},   bus.cfg_data, 8'h00);
        chk({tag, " tx_data"},    bus.tx_data, 8'h00);
    endtask

    task automatic apply_vec(input vec_t v);
        send_byte(v.b0);
        send_byte(v.b1);
        send_byte(v.b2);
        // one cycle after the third byte was accepted
        chk("vec start_dump", bus.start_dump, v.sd);
        chk("vec cfg_wr", bus.cfg_wr, v.cw);
        chk("vec dump_ch", bus.dump_ch, v.ch);
        chk("vec dump_addr", bus.dump_addr, v.da);
        chk("vec cfg_addr", bus.cfg_addr, v.ca);
        chk("vec cfg_data", bus.cfg_data, v.cd);
        chk("vec tx_data", bus.tx_data, v.tx);
        chk("vec busy", bus.busy, 1'b1);
        chk("vec trmt early", bus.trmt, 1'b0);
        step();
        chk("vec start_dump width", bus.start_dump, 1'b0);
        chk("vec cfg_wr width", bus.cfg_wr, 1'b0);
        chk("vec trmt", bus.trmt, !v.sd);
        step();
        chk("vec trmt width", bus.trmt, 1'b0);
        chk("vec busy waiting", bus.busy, 1'b1);
        if (v.sd) begin
            pulse_dump_done();
        end else begin
            chk("vec tx_data held", bus.tx_data, v.tx);
            pulse_tx_done();
        end
        chk("vec busy released", bus.busy, 1'b0);
    endtask

    // Transaction-level model: what a complete command must produce.
    function automatic void model_cmd(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        case (b0[7:4])
            4'h1: exp_q.push_back('{0, {6'd0, b0[1:0]}, b2});
            4'h2: begin
                exp_q.push_back('{1, b2, b1});
                exp_q.push_back('{2, 8'hA5, 8'h00});
            end
            default: exp_q.push_back('{2, 8'hEE, 8'h00});
        endcase
    endfunction

    vec_t vecs[6];

    initial begin
        logic [7:0] b0, b1, b2;
        int sel, drop_at, w;

        vecs[0] = '{8'h12, 8'h00, 8'h40, 1'b1, 2'd2, 8'h40, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[1] = '{8'h20, 8'h5C, 8'h07, 1'b0, 2'd2, 8'h40, 1'b1, 8'h07, 8'h5C, 8'hA5};
        vecs[2] = '{8'hF0, 8'h00, 8'h00, 1'b0, 2'd2, 8'h40, 1'b0, 8'h07, 8'h5C, 8'hEE};
        vecs[3] = '{8'h1F, 8'h00, 8'hAB, 1'b1, 2'd3, 8'hAB, 1'b0, 8'h07, 8'h5C, 8'hEE};
        vecs[4] = '{8'h2C, 8'hFF, 8'h00, 1'b0, 2'd3, 8'hAB, 1'b1, 8'h00, 8'hFF, 8'hA5};
        vecs[5] = '{8'h00, 8'h12, 8'h34, 1'b0, 2'd3, 8'hAB, 1'b0, 8'h00, 8'hFF, 8'hEE};

        rst_n = 1'b0;
        bus.rx_data = 8'h00;
        bus.rx_rdy = 1'b0;
        bus.dump_done = 1'b0;
        bus.tx_done = 1'b0;
        repeat (3) step();
        chk_reset_outputs("reset");
        chk("reset clr_rx_rdy", bus.clr_rx_rdy, 1'b0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) apply_vec(vecs[i]);

        // Partial command abandoned after TO idle cycles; next command starts fresh.
        send_byte(8'h20);
        repeat (TO - 1) step();
        chk("timeout not yet", bus.busy, 1'b1);
        step();
        chk("timeout expired", bus.busy, 1'b0);
        apply_vec('{8'h20, 8'h11, 8'h03, 1'b0, 2'd3, 8'hAB, 1'b1, 8'h03, 8'h11, 8'hA5});

        // A byte arriving on the last allowed cycle is still part of the command.
        send_byte(8'h20);
        repeat (TO - 1) step();
        send_byte(8'h66);
        send_byte(8'h09);
        chk("late byte cfg_wr", bus.cfg_wr, 1'b1);
        chk("late byte cfg_addr", bus.cfg_addr, 8'h09);
        chk("late byte cfg_data", bus.cfg_data, 8'h66);
        step();
        step();
        pulse_tx_done();
        chk("late byte busy released", bus.busy, 1'b0);

        // Byte and stray tx_done during DUMP_WAIT, then reset mid-dump.
        send_byte(8'h12);
        send_byte(8'h00);
        send_byte(8'h40);
        step();
        send_byte(8'h21);
        chk("busy byte busy", bus.busy, 1'b1);
        chk("busy byte start_dump", bus.start_dump, 1'b0);
        chk("busy byte cfg_wr", bus.cfg_wr, 1'b0);
        chk("busy byte dump_addr", bus.dump_addr, 8'h40);
        chk("busy byte dump_ch", bus.dump_ch, 2'd2);
        pulse_tx_done();
        chk("stray tx_done busy", bus.busy, 1'b1);
        chk("stray tx_done trmt", bus.trmt, 1'b0);
        rst_n = 1'b0;
        step();
        chk_reset_outputs("mid-dump reset");
        rst_n = 1'b1;
        step();
        pulse_dump_done();
        chk("dump_done after reset ignored", bus.busy, 1'b0);

        // Randomized commands against the transaction model.
        mon_q.delete();
        exp_q.delete();
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 2);
            b0 = 8'($urandom);
            if (sel == 0) b0[7:4] = 4'h1;
            else if (sel == 1) b0[7:4] = 4'h2;
            b1 = 8'($urandom);
            b2 = 8'($urandom);
            drop_at = ($urandom_range(0, 6) == 0) ? $urandom_range(1, 2) : 0;

            send_byte(b0);
            if (drop_at == 1) begin
                idle_cycles(TO, 1'b1);
                chk("rand drop busy", bus.busy, 1'b0);
                continue;
            end
            idle_cycles($urandom_range(0, TO - 1), 1'b1);
            send_byte(b1);
            if (drop_at == 2) begin
                idle_cycles(TO, 1'b1);
                chk("rand drop busy", bus.busy, 1'b0);
                continue;
            end
            idle_cycles($urandom_range(0, TO - 1), 1'b1);
            send_byte(b2);
            model_cmd(b0, b1, b2);

            step();
            if (b0[7:4] != 4'h1) step();
            w = $urandom_range(0, 6);
            for (int k = 0; k < w; k++) begin
                if ($urandom_range(0, 2) == 0) send_byte(8'($urandom));
                else step();
            end
            chk("rand busy before done", bus.busy, 1'b1);
            if (b0[7:4] == 4'h1) pulse_dump_done();
            else pulse_tx_done();
            chk("rand busy released", bus.busy, 1'b0);
            idle_cycles($urandom_range(0, 3), 1'b1);
        end
        step();
        chk("rand event count", mon_q.size(), exp_q.size());
        for (int i = 0; i < mon_q.size() && i < exp_q.size(); i++) begin
            chk("rand event kind", mon_q[i].kind, exp_q[i].kind);
            chk("rand event a", mon_q[i].a, exp_q[i].a);
            chk("rand event b", mon_q[i].b, exp_q[i].b);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
